// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative signed shift-add multiplier, one multiplier bit per clock.
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      request, sampled only in IDLE
//   i_a, i_b     signed WIDTH-bit operands, captured on the accepting edge
//   o_busy       high whenever not IDLE
//   o_done       one-cycle registered pulse, product valid
//   o_result     low WIDTH bits of the product
//   o_result_hi  high WIDTH bits of the product
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_acc, r_mcand, w_pp, w_acc;
  logic               w_last;
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign o_busy = r_state != S_IDLE;
  assign o_done = r_state == S_DONE;
  always_comb begin
    w_next = r_state == S_IDLE ? (i_start ? S_BUSY : S_IDLE) :
             r_state == S_BUSY ? (w_last ? S_DONE : S_BUSY) : S_IDLE;
    w_pp   = r_mplr[0] ? r_mcand : '0;
    // the multiplier's sign bit carries weight -2^(WIDTH-1), so its partial product is subtracted
    w_acc  = w_last ? r_acc - w_pp : r_acc + w_pp;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_mplr      <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      o_result    <= '0;
      o_result_hi <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_cnt   <= '0;
      r_mplr  <= i_b;
      r_acc   <= '0;
      r_mcand <= {{WIDTH{i_a[WIDTH-1]}}, i_a};
    end else if (r_state == S_BUSY) begin
      r_cnt   <= r_cnt + CW'(1);
      r_mplr  <= r_mplr >> 1;
      r_acc   <= w_acc;
      r_mcand <= r_mcand << 1;
      if (w_last) {o_result_hi, o_result} <= w_acc;
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: vector table, handshake sequences and random products against a 64-bit model.
module tb_seq_multiplier;
  localparam int W = 32;
  logic clk = 0, rst = 1, start = 0;
  logic [W-1:0] a = 0, b = 0, res, res_hi;
  logic busy, done;
  int n_checks = 0, n_fail = 0;
  seq_multiplier #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_result(res), .o_result_hi(res_hi)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] a, b, lo, hi;
  } vec_t;
  vec_t vt[9];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return 64'(p);
  endfunction
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string nm,
                        output logic [63:0] got);
    logic [63:0] held;
    bit stable;
    int n;
    held = {res_hi, res};
    stable = 1;
    @(negedge clk);
    start = 1; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 0; a = $urandom; b = $urandom;
    chk({nm, " busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 100) begin
      if ({res_hi, res} !== held) stable = 0;
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(W));
    got = {res_hi, res};
    chk({nm, " product"}, got, model(x, y));
    chk({nm, " held"}, 64'(stable), 64'd1);
    @(negedge clk);
    chk({nm, " done pulse"}, {62'd0, busy, done}, 64'd0);
  endtask
  initial begin
    logic [63:0] got;
    logic [W-1:0] x, y, pool[5];
    int n, pulses;
    vt[0] = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 32'hFFFFFFFF};
    vt[1] = '{32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000};
    vt[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h3FFFFFFF};
    vt[3] = '{32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hC0000000};
    vt[4] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h00000000};
    vt[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vt[6] = '{32'd0, 32'h12345678, 32'h00000000, 32'h00000000};
    vt[7] = '{32'd2, 32'd3, 32'd6, 32'd0};
    vt[8] = '{32'hFFFFFFFE, 32'd1, 32'hFFFFFFFE, 32'hFFFFFFFF};
    pool[0] = 0; pool[1] = 1; pool[2] = 32'hFFFFFFFF; pool[3] = 32'h80000000; pool[4] = 32'h7FFFFFFF;
    repeat (3) @(negedge clk);
    chk("reset outputs", {busy, done, res_hi, res}, 66'd0);
    rst = 0;
    @(negedge clk);
    chk("idle after reset", {62'd0, busy, done}, 64'd0);
    for (int i = 0; i < 9; i++) begin
      run_op(vt[i].a, vt[i].b, $sformatf("vec%0d", i), got);
      chk($sformatf("vec%0d table", i), got, {vt[i].hi, vt[i].lo});
    end
    start = 1; a = 3; b = 4;
    @(posedge clk);
    @(negedge clk);
    chk("hold busy rise", 64'(busy), 64'd1);
    a = 10; b = 11;
    wait_done(n);
    chk("hold latency", 64'(n), 64'(W));
    chk("hold first product", {res_hi, res}, 64'd12);
    @(negedge clk);
    chk("hold back to idle", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    chk("hold reaccept", 64'(busy), 64'd1);
    start = 0;
    wait_done(n);
    chk("hold second latency", 64'(n), 64'(W));
    chk("hold second product", {res_hi, res}, 64'd110);
    @(negedge clk);
    start = 1; a = 2; b = 3;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    start = 1; a = 5; b = 6;
    @(negedge clk);
    start = 0;
    pulses = 0;
    repeat (70) begin
      if (done) pulses++;
      @(negedge clk);
    end
    chk("ignored start pulses", 64'(pulses), 64'd1);
    chk("ignored start product", {res_hi, res}, 64'd6);
    start = 1; a = 100; b = 100;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    #1;
    chk("abort outputs", {busy, done, res_hi, res}, 66'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) pulses++;
    end
    rst = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort no done", 64'(pulses), 64'd0);
    chk("abort result stays 0", {res_hi, res}, 64'd0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, "after abort", got);
    chk("after abort value", got, 64'd1);
    for (int i = 0; i < 1000; i++) begin
      x = ($urandom_range(3) == 0) ? pool[$urandom_range(4)] : $urandom;
      y = ($urandom_range(3) == 0) ? pool[$urandom_range(4)] : $urandom;
      run_op(x, y, $sformatf("rnd%0d", i), got);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
